wm8731_i2c_slave: RTL and testbench

- Synthesizable model of the WM8731 2-wire control port: the responder for the I2C initiator inside codec_avalon.
- Connects to the i2c_sclk/i2c_sdat nets.
- Decodes 3-byte write transactions (device address, {reg[6:0],data[8]}, data[7:0]), ACKs them, and stores data in a shadow register file.
- Used in closed-loop benches and FPGA loopback builds to check configuration sequences.

---
 rtl/wm8731_i2c_slave.sv | 201 ++++++++++++++++++++
 tb/tb_wm8731_i2c_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_i2c_slave.sv
// WM8731 2-wire control port responder: write-only, 3-byte transactions,
// shadow register file R0..R9 with reset register at 0x0F.
module wm8731_i2c_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       reg_wr_strobe,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic [7:0] wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK_1,
        BYTE2,
        ACK_2,
        WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, sdat_sync;
    logic sclk_d, sdat_d;
    logic sclk_s, sdat_s;
    logic sclk_rise, sclk_fall;
    logic start_ev, stop_ev;

    logic [2:0] bit_cnt;
    logic       byte_full;
    logic [7:0] shift;
    logic [7:0] byte1;
    logic       clr_cnt, ld_b1, commit;
    logic       shifting;
    logic [6:0] c_addr;
    logic [8:0] c_data;

    logic [8:0] regs [0:9];

    function automatic logic [8:0] reg_def(input int i);
        case (i)
            0, 1:    reg_def = 9'h097;
            2, 3:    reg_def = 9'h079;
            4:       reg_def = 9'h00A;
            5:       reg_def = 9'h008;
            6:       reg_def = 9'h09F;
            7:       reg_def = 9'h00A;
            default: reg_def = 9'h000;
        endcase
    endfunction

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdat_s    = sdat_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    // bus events only count while sclk has been stably high
    assign start_ev  = sclk_s & sclk_d & sdat_d & ~sdat_s;
    assign stop_ev   = sclk_s & sclk_d & ~sdat_d & sdat_s;

    assign shifting = (state == ADDR) || (state == BYTE1) || (state == BYTE2);
    assign busy     = (state != IDLE);
    assign c_addr   = byte1[7:1];
    assign c_data   = {byte1[0], shift};

    // open-drain: only ever pull low, released straight from the state reg
    assign i2c_sdat = ((state == ACK_A) || (state == ACK_1) || (state == ACK_2))
                      ? 1'b0 : 1'bz;

    // synchronize the bus pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '1;
            sdat_sync <= '1;
            sclk_d    <= 1'b1;
            sdat_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i2c_sclk};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], i2c_sdat};
            sclk_d    <= sclk_s;
            sdat_d    <= sdat_s;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state; bus START/STOP take priority over sclk edges
    always_comb begin
        state_n = state;
        clr_cnt = 1'b0;
        ld_b1   = 1'b0;
        commit  = 1'b0;
        if (start_ev) begin
            state_n = ADDR;
            clr_cnt = 1'b1;
        end else if (stop_ev) begin
            state_n = IDLE;
        end else if (sclk_fall) begin
            unique case (state)
                ADDR: begin
                    if (byte_full)
                        state_n = (shift == {DEV_ADDR, 1'b0}) ? ACK_A : IDLE;
                end
                ACK_A: begin
                    state_n = BYTE1;
                    clr_cnt = 1'b1;
                end
                BYTE1: begin
                    if (byte_full) begin
                        state_n = ACK_1;
                        ld_b1   = 1'b1;
                    end
                end
                ACK_1: begin
                    state_n = BYTE2;
                    clr_cnt = 1'b1;
                end
                BYTE2: begin
                    if (byte_full) state_n = ACK_2;
                end
                ACK_2: begin
                    state_n = WAIT_STOP;
                    commit  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // shift in bits on sclk rise, MSB first, while receiving a byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            byte_full <= 1'b0;
            shift     <= '0;
            byte1     <= '0;
        end else begin
            if (clr_cnt) begin
                bit_cnt   <= '0;
                byte_full <= 1'b0;
            end else if (sclk_rise && shifting) begin
                shift   <= {shift[6:0], sdat_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end
            if (ld_b1) byte1 <= shift;
        end
    end

    // commit outputs: one-cycle strobe, held address/data, write counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            wr_count      <= '0;
        end else begin
            reg_wr_strobe <= commit;
            if (commit) begin
                reg_wr_addr <= c_addr;
                reg_wr_data <= c_data;
                wr_count    <= wr_count + 8'd1;
            end
        end
    end

    // shadow register file; address 0x0F restores all defaults
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 10; i++) regs[i] <= reg_def(i);
        end else if (commit) begin
            unique case (1'b1)
                (c_addr <= 7'd9): regs[c_addr[3:0]] <= c_data;
                (c_addr == 7'h0F): begin
                    for (int i = 0; i < 10; i++) regs[i] <= reg_def(i);
                end
                default: ;
            endcase
        end
    end

    // combinational read port
    always_comb begin
        rd_data = '0;
        if (rd_addr <= 4'd9) rd_data = regs[rd_addr];
    end

endmodule

// File: tb/tb_wm8731_i2c_slave.sv
// Directed bench for wm8731_i2c_slave: bit-banged I2C initiator,
// strobe monitor and hand-computed expectations.
module tb_wm8731_i2c_slave;

    localparam int HP = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b1;
    logic       m_oe = 1'b0;
    logic [3:0] rd_addr = '0;
    wire        sdat;
    logic       reg_wr_strobe;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic [8:0] rd_data;
    logic       busy;
    logic [7:0] wr_count;

    int n_chk = 0;
    int n_fail = 0;
    int strobes = 0;
    int run = 0;
    int max_run = 0;

    pullup (sdat);
    assign sdat = m_oe ? 1'b0 : 1'bz;

    wm8731_i2c_slave dut (
        .clk          (clk),
        .reset        (reset),
        .i2c_sclk     (sclk),
        .i2c_sdat     (sdat),
        .reg_wr_strobe(reg_wr_strobe),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .wr_count     (wr_count)
    );

    always #10 clk = ~clk;

    // count strobes and their widest pulse
    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            if (run == 0) strobes++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [8:0] e);
        rd_addr = a;
        #1;
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic i2c_start;
        m_oe = 1'b0;
        wclk(HP);
        sclk = 1'b1;
        wclk(HP);
        m_oe = 1'b1;
        wclk(HP);
        sclk = 1'b0;
        wclk(5);
    endtask

    task automatic i2c_stop;
        m_oe = 1'b1;
        wclk(HP);
        sclk = 1'b1;
        wclk(HP);
        m_oe = 1'b0;
        wclk(HP);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_oe = ~b[i];
            wclk(HP);
            sclk = 1'b1;
            wclk(HP);
            sclk = 1'b0;
            wclk(5);
        end
        m_oe = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b,
                             input logic exp_ack);
        logic a;
        send_bits(b);
        wclk(HP);
        sclk = 1'b1;
        wclk(HP / 2);
        a = (sdat === 1'b0);
        wclk(HP / 2);
        sclk = 1'b0;
        wclk(5);
        chk(tag, 32'(a), 32'(exp_ack));
    endtask

    initial begin
        wclk(3);
        chk("rst_sdat", 32'(sdat), 32'h1);
        reset = 1'b0;
        wclk(5);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobe", 32'(reg_wr_strobe), 32'h0);
        chk("rst_addr", 32'(reg_wr_addr), 32'h0);
        chk("rst_data", 32'(reg_wr_data), 32'h0);
        chk("rst_cnt", 32'(wr_count), 32'h0);
        rd_chk("rst_r0", 4'd0, 9'h097);
        rd_chk("rst_r2", 4'd2, 9'h079);
        rd_chk("rst_r5", 4'd5, 9'h008);
        rd_chk("rst_r6", 4'd6, 9'h09F);
        rd_chk("rst_r10", 4'd10, 9'h000);

        // write R4 = 0x012
        i2c_start();
        chk("busy_start", 32'(busy), 32'h1);
        send_byte("w4_ack_a", 8'h34, 1'b1);
        send_byte("w4_ack_1", 8'h08, 1'b1);
        send_byte("w4_ack_2", 8'h12, 1'b1);
        i2c_stop();
        chk("w4_busy", 32'(busy), 32'h0);
        chk("w4_strobes", 32'(strobes), 32'd1);
        chk("w4_addr", 32'(reg_wr_addr), 32'h04);
        chk("w4_data", 32'(reg_wr_data), 32'h012);
        chk("w4_cnt", 32'(wr_count), 32'd1);
        rd_chk("w4_r4", 4'd4, 9'h012);

        // wrong device address
        i2c_start();
        send_byte("bad_nack", 8'h36, 1'b0);
        chk("bad_busy", 32'(busy), 32'h0);
        send_byte("bad_b1", 8'h08, 1'b0);
        send_byte("bad_b2", 8'h55, 1'b0);
        i2c_stop();
        chk("bad_strobes", 32'(strobes), 32'd1);
        rd_chk("bad_r4", 4'd4, 9'h012);

        // read request is NACKed, then a valid write of R7 = 0x11F
        i2c_start();
        send_byte("rd_nack", 8'h35, 1'b0);
        i2c_stop();
        chk("rd_strobes", 32'(strobes), 32'd1);
        i2c_start();
        send_byte("w7_ack_a", 8'h34, 1'b1);
        send_byte("w7_ack_1", 8'h0F, 1'b1);
        send_byte("w7_ack_2", 8'h1F, 1'b1);
        i2c_stop();
        rd_chk("w7_r7", 4'd7, 9'h11F);
        chk("w7_cnt", 32'(wr_count), 32'd2);

        // R0 = 0x01F then reset register
        i2c_start();
        send_byte("w0_ack_a", 8'h34, 1'b1);
        send_byte("w0_ack_1", 8'h00, 1'b1);
        send_byte("w0_ack_2", 8'h1F, 1'b1);
        i2c_stop();
        rd_chk("w0_r0", 4'd0, 9'h01F);
        i2c_start();
        send_byte("rr_ack_a", 8'h34, 1'b1);
        send_byte("rr_ack_1", 8'h1E, 1'b1);
        send_byte("rr_ack_2", 8'h00, 1'b1);
        i2c_stop();
        chk("rr_addr", 32'(reg_wr_addr), 32'h0F);
        chk("rr_data", 32'(reg_wr_data), 32'h000);
        chk("rr_cnt", 32'(wr_count), 32'd4);
        rd_chk("rr_r0", 4'd0, 9'h097);
        rd_chk("rr_r4", 4'd4, 9'h00A);
        rd_chk("rr_r7", 4'd7, 9'h00A);

        // aborted writes, then repeated START completes R1 = 0x055
        i2c_start();
        send_byte("ab_ack_a", 8'h34, 1'b1);
        send_byte("ab_ack_1", 8'h08, 1'b1);
        i2c_stop();
        chk("ab_strobes", 32'(strobes), 32'd4);
        i2c_start();
        send_byte("rs_ack_a0", 8'h34, 1'b1);
        send_byte("rs_ack_10", 8'h08, 1'b1);
        i2c_start();
        send_byte("rs_ack_a", 8'h34, 1'b1);
        send_byte("rs_ack_1", 8'h02, 1'b1);
        send_byte("rs_ack_2", 8'h55, 1'b1);
        send_byte("rs_extra", 8'hA5, 1'b0);
        i2c_stop();
        chk("rs_strobes", 32'(strobes), 32'd5);
        chk("rs_cnt", 32'(wr_count), 32'd5);
        chk("rs_addr", 32'(reg_wr_addr), 32'h01);
        chk("rs_data", 32'(reg_wr_data), 32'h055);
        rd_chk("rs_r1", 4'd1, 9'h055);
        rd_chk("rs_r4", 4'd4, 9'h00A);

        // reset while the device drives ACK_1
        i2c_start();
        send_byte("ra_ack_a", 8'h34, 1'b1);
        send_bits(8'h10);
        wclk(5);
        chk("ra_drv", 32'(sdat), 32'h0);
        rd_addr = 4'd1;
        reset = 1'b1;
        #1;
        chk("ra_rel", 32'(sdat), 32'h1);
        chk("ra_r1", 32'(rd_data), 32'h097);
        chk("ra_cnt", 32'(wr_count), 32'd0);
        chk("ra_busy", 32'(busy), 32'h0);
        wclk(2);
        reset = 1'b0;
        wclk(5);
        i2c_start();
        send_byte("w8_ack_a", 8'h34, 1'b1);
        send_byte("w8_ack_1", 8'h10, 1'b1);
        send_byte("w8_ack_2", 8'hAA, 1'b1);
        i2c_stop();
        rd_chk("w8_r8", 4'd8, 9'h0AA);
        chk("w8_cnt", 32'(wr_count), 32'd1);
        chk("w8_strobes", 32'(strobes), 32'd6);
        chk("strobe_width", 32'(max_run), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
